// File: rtl/minisrc_pkg.sv
// Shared datapath definitions for the minisrc core: divider FSM states and
// divide-related constants.
package minisrc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } div_state_t;

  localparam logic [4:0]  DIV_OPCODE    = 5'b10000;
  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bundle between the control
// sequencer (master) and the sequential divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                      start;
  logic signed [WIDTH-1:0]   dividend;
  logic signed [WIDTH-1:0]   divisor;
  logic                      busy;
  logic                      done;
  logic                      div_zero;
  logic        [2*WIDTH-1:0] result;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, result
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, result
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    // The extra top bit of diff acts as the borrow: set means restore.
    qbit_o  = ~diff[WIDTH+1];
    rem_o   = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider producing {remainder, quotient} for the div
// instruction. Optional macro DIV_ZERO_FAST_EN short-cuts a zero divisor.
module div_unit
  import minisrc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      clr,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] dvd_q, dvd_d;
  logic signed [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [WIDTH:0]          rem_q, rem_d;
  logic                    qsign_q, qsign_d;
  logic                    rsign_q, rsign_d;
  logic [2*WIDTH-1:0]      result_q, result_d;
  logic                    done_q, done_d;
  logic                    dz_q, dz_d;

  logic [WIDTH:0]          step_rem;
  logic                    step_qbit;

  // Two's-complement magnitude; the most negative value maps onto itself and
  // is then read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (a_q[WIDTH-1]),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          qsign_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rsign_d = bus.dividend[WIDTH-1];
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        a_d     = abs_val(dvd_q);
        b_d     = abs_val(dvs_q);
        rem_d   = '0;
        cnt_d   = CNT_W'(DIV_ITERS - 1);
        state_d = S_ITER;
`ifdef DIV_ZERO_FAST_EN
        if (dvs_q == '0) state_d = S_FIX;
`endif
      end

      // a_q shifts dividend bits out of the top and quotient bits in at the
      // bottom, so it holds the unsigned quotient once the count expires.
      S_ITER: begin
        rem_d = step_rem;
        a_d   = {a_q[WIDTH-2:0], step_qbit};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      S_FIX: begin
        if (dvs_q == '0) begin
          result_d = {dvd_q, WIDTH'(DIV_ZERO_QUOT)};
          dz_d     = 1'b1;
        end else begin
          result_d = {sign_fix(rem_q[WIDTH-1:0], rsign_q), sign_fix(a_q, qsign_q)};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    a_q     <= a_d;
    b_q     <= b_d;
    rem_q   <= rem_d;
    qsign_q <= qsign_d;
    rsign_q <= rsign_d;
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.result   = result_q;

endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-bit signed divider that produces the 64-bit result written into the Z register for the `div` instruction. It sits directly downstream of the bus/Y-register operand path in the datapath and replaces the combinational divide path. The result format matches Z: remainder in the high word (`Zhigh` → HI), quotient in the low word (`Zlow` → LO). It uses a start/busy/done handshake, so the control sequencer holds its T4 step until `done`.

## Interface
- `WIDTH`, 32, operand width; the result is 2*WIDTH.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  signed dividend (Y register contents).
- `divisor`  in  WIDTH  signed divisor (bus contents).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `div_zero`  out  1  set with `done` when the divisor was 0; held until the next accepted start.
- `result`  out  2*WIDTH  {remainder, quotient}; held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX.
- **IDLE**
  - On `start`, capture `dividend` and `divisor`.
  - Record the quotient sign as `dividend[31]^divisor[31]` and the remainder sign as `dividend[31]`.
  - Clear `div_zero`, then go to PREP.
  - `start` in any other state is ignored; it is not queued.
- **PREP**
  - Take the absolute values; `|0x80000000|` stays `0x80000000`, treated as unsigned.
  - Clear the 33-bit partial remainder, load the counter with 31, then go to ITER.
- **ITER** (restoring, one quotient bit per cycle, MSB first)
  - Shift the remainder left and bring in the next dividend bit.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - At counter 0, go to FIX; otherwise decrement the counter.
- **FIX**
  - Negate the quotient if its sign is 1; negate the remainder if its sign is 1 (truncating division, C semantics).
  - Write `result`, pulse `done`, return to IDLE.
- **Divide by zero:** quotient = `0xFFFFFFFF`, remainder = dividend (original signed value), `div_zero` = 1. This falls out of the restoring algorithm after sign fix only if forced, so FIX must override it explicitly.
- **Overflow** `0x80000000 / 0xFFFFFFFF`: quotient `0x80000000`, remainder 0. There is no flag.
- **`clr`** at any edge, including mid-ITER: state goes to IDLE and `result`, `done`, `div_zero` and `busy` go to 0. The in-flight operation is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `result`=0.
- Cycle-by-cycle, with `start` sampled at edge E0:
  - PREP completes at E1.
  - ITER occupies E2..E33.
  - FIX completes at E34.
  - `done` is high for exactly the cycle after E34. Latency is 34 clocks, start to `done`.
- `busy` rises after E0 and falls after E34, in the same cycle `done` rises.
- `start` high in the `done` cycle is accepted, since the state is IDLE; back-to-back throughput is one result per 34 clocks.
- Operands only need to be stable in the E0 setup window.

## Configuration
- **`DIV_ZERO_FAST_EN`**
  - Defined: PREP detects divisor == 0 and goes straight to FIX, so `done` arrives after E2, a latency of 2 clocks.
  - Undefined: a zero divisor runs the full 32 iterations and FIX forces the defined result; latency is 34.
  - Result values are identical in both builds.

## Structure
- Shared package `minisrc_pkg` holds:
  - the state enum `div_state_t`;
  - `DIV_OPCODE` = 5'b10000;
  - `DIV_ITERS` = 32;
  - `DIV_ZERO_QUOT` = 32'hFFFFFFFF.
- One combinational sub-module, `div_step`, contains:
  - input: 33-bit remainder, next dividend bit, divisor;
  - output: next remainder, quotient bit.
- The FSM, counter and sign fix stay in `div_unit`.

## Test plan
- `0x144EA4EA / 0xFFFFFF38` → `result` = `0x00000092_FFE601BD`, `done` 34 clocks after start, `div_zero`=0.
- `-7 / 2` (`0xFFFFFFF9 / 0x2`) → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`; `100 / 7` → `0x00000002_0000000E`.
- `0x00001234 / 0` → `result` = `0x00001234_FFFFFFFF`, `div_zero`=1; latency 34 without the macro, 2 with `DIV_ZERO_FAST_EN`.
- `0x80000000 / 0xFFFFFFFF` → `0x00000000_80000000`.
- `clr` at cycle 15 of an operation → all outputs 0 next cycle. A `start` pulsed while `busy` is ignored (`result` unchanged, single `done`). A `start` in the `done` cycle begins the next operation.
